// File: rtl/anton_neopixel_registers_multi.sv
// Multi-channel NeoPixel register file and pixel frame buffers sitting between the
// byte-wide bus slave and CHANNELS independent stream engines.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 2047
`endif

module anton_neopixel_registers_multi #(
    parameter int BUFFER_END = `BUFFER_END_DEFAULT,
    parameter int CHANNELS   = 2,
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
    input  logic                            busClk,
    input  logic                            busResetN,
    input  logic [17:0]                     busAddr,
    input  logic [7:0]                      busDataIn,
    input  logic                            busWrite,
    input  logic                            busRead,
    output logic [7:0]                      busDataOut,
    input  logic [CHANNELS*BUFFER_BITS-1:0] pixelIxComb,
    output logic [CHANNELS*8-1:0]           pixelByte,
    input  logic [CHANNELS-1:0]             streamSyncOf,
    input  logic [CHANNELS-1:0]             syncStart,
    input  logic [CHANNELS-1:0]             state,
    input  logic [CHANNELS-1:0]             initSlowDone,
    output logic [CHANNELS*13-1:0]          regMax,
    output logic [CHANNELS-1:0]             regCtrlInit,
    output logic [CHANNELS-1:0]             regCtrlLimit,
    output logic [CHANNELS-1:0]             regCtrlRun,
    output logic [CHANNELS-1:0]             regCtrlLoop,
    output logic [CHANNELS-1:0]             regCtrl32bit,
    output logic [CHANNELS-1:0]             initSlow,
    output logic                            irq
);

    localparam logic [3:0] REG_MAX_L     = 4'd0;
    localparam logic [3:0] REG_MAX_H     = 4'd1;
    localparam logic [3:0] REG_CTRL      = 4'd2;
    localparam logic [3:0] REG_STATUS    = 4'd3;
    localparam logic [3:0] REG_IRQ_STAT  = 4'd4;
    localparam logic [3:0] REG_IRQ_EN    = 4'd5;
    localparam logic [3:0] REG_FRAME_CNT = 4'd6;

    logic [CHANNELS-1:0]    r_init, r_limit, r_run, r_loop, r_b32, r_initSlow;
    logic [12:0]            r_maxB [CHANNELS];
    logic [12:0]            r_max  [CHANNELS];
    logic [1:0]             r_stat [CHANNELS];
    logic [1:0]             r_en   [CHANNELS];
    logic [7:0]             r_cnt  [CHANNELS];
    logic                   r_irq;
    logic [7:0]             r_dataOut;
    logic [CHANNELS-1:0]    r_bufWe;
    logic [BUFFER_BITS-1:0] r_bufAddr;
    logic [7:0]             r_bufData;

    logic [CHANNELS-1:0]    w_initNext, w_limitNext, w_runNext, w_loopNext, w_b32Next, w_initSlowNext;
    logic [12:0]            w_maxBNext [CHANNELS];
    logic [12:0]            w_maxNext  [CHANNELS];
    logic [1:0]             w_statNext [CHANNELS];
    logic [1:0]             w_enNext   [CHANNELS];
    logic [7:0]             w_cntNext  [CHANNELS];
    logic [CHANNELS-1:0]    w_regWr, w_bufWe;
    logic                   w_irqNext;
    logic [7:0]             w_rdData;
    logic                   w_isBuf, w_chValid, w_unused;
    logic [1:0]             w_ch;
    logic [3:0]             w_off;

    assign w_isBuf   = (busAddr[17:16] == 2'b00);
    assign w_ch      = w_isBuf ? busAddr[15:14] : busAddr[5:4];
    assign w_chValid = (32'(w_ch) < 32'(CHANNELS));
    assign w_off     = busAddr[3:0];
    assign w_unused  = ^busAddr;

    // Per-channel write strobes for the register file and the pixel RAMs.
    always_comb begin
        w_regWr = '0;
        w_bufWe = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_regWr[c] = busWrite && !w_isBuf && (w_ch == 2'(c));
            w_bufWe[c] = busWrite &&  w_isBuf && (w_ch == 2'(c));
        end
    end

    // Event priority per channel: later statements override earlier ones, and the
    // init hold checks the already-updated init bit so initSlowDone can release it.
    always_comb begin
        w_initNext     = r_init;
        w_limitNext    = r_limit;
        w_runNext      = r_run;
        w_loopNext     = r_loop;
        w_b32Next      = r_b32;
        w_initSlowNext = r_initSlow;
        w_maxBNext     = r_maxB;
        w_maxNext      = r_max;
        w_statNext     = r_stat;
        w_enNext       = r_en;
        w_cntNext      = r_cnt;
        w_irqNext      = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (streamSyncOf[c]) begin
                w_runNext[c] = r_loop[c];
                w_cntNext[c] = r_cnt[c] + 8'd1;
            end
            if (syncStart[c]) begin
                w_runNext[c] = 1'b1;
            end
            if (initSlowDone[c]) begin
                w_initNext[c]     = 1'b0;
                w_initSlowNext[c] = 1'b0;
            end
            if (w_initNext[c]) begin
                w_limitNext[c]    = 1'b0;
                w_runNext[c]      = 1'b0;
                w_loopNext[c]     = 1'b0;
                w_b32Next[c]      = 1'b0;
                w_initSlowNext[c] = 1'b1;
            end
            if (w_regWr[c]) begin
                case (w_off)
                    REG_MAX_L:  w_maxBNext[c][7:0]  = busDataIn;
                    REG_MAX_H:  w_maxBNext[c][12:8] = busDataIn[4:0];
                    REG_CTRL:   {w_b32Next[c], w_loopNext[c], w_runNext[c],
                                 w_limitNext[c], w_initNext[c]} = busDataIn[4:0];
                    REG_IRQ_EN: w_enNext[c] = busDataIn[1:0];
                    default:    ;
                endcase
            end
            w_statNext[c] = (r_stat[c] & ~((w_regWr[c] && w_off == REG_IRQ_STAT) ? busDataIn[1:0] : 2'b00))
                          | {initSlowDone[c], streamSyncOf[c]};
            if (syncStart[c] || !r_run[c]) begin
                w_maxNext[c] = w_maxBNext[c];
            end
            w_irqNext = w_irqNext | (|(r_stat[c] & r_en[c]));
        end
    end

    // Read mux always reflects the pre-write register values.
    always_comb begin
        w_rdData = 8'h00;
        if (w_chValid) begin
            if (w_isBuf) begin
                w_rdData = 8'hFF;
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_ch == 2'(c)) begin
                        case (w_off)
                            REG_MAX_L:     w_rdData = r_maxB[c][7:0];
                            REG_MAX_H:     w_rdData = {3'b0, r_maxB[c][12:8]};
                            REG_CTRL:      w_rdData = {3'b0, r_b32[c], r_loop[c], r_run[c], r_limit[c], r_init[c]};
                            REG_STATUS:    w_rdData = {6'b0, r_initSlow[c], state[c]};
                            REG_IRQ_STAT:  w_rdData = {6'b0, r_stat[c]};
                            REG_IRQ_EN:    w_rdData = {6'b0, r_en[c]};
                            REG_FRAME_CNT: w_rdData = r_cnt[c];
                            default:       w_rdData = 8'h00;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge busClk or negedge busResetN) begin
        if (!busResetN) begin
            r_init     <= '0;
            r_limit    <= '0;
            r_run      <= '0;
            r_loop     <= '0;
            r_b32      <= '0;
            r_initSlow <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_maxB[c] <= '0;
                r_max[c]  <= '0;
                r_stat[c] <= '0;
                r_en[c]   <= '0;
                r_cnt[c]  <= '0;
            end
            r_irq     <= 1'b0;
            r_dataOut <= 8'h00;
            r_bufWe   <= '0;
            r_bufAddr <= '0;
            r_bufData <= 8'h00;
        end else begin
            r_init     <= w_initNext;
            r_limit    <= w_limitNext;
            r_run      <= w_runNext;
            r_loop     <= w_loopNext;
            r_b32      <= w_b32Next;
            r_initSlow <= w_initSlowNext;
            r_maxB     <= w_maxBNext;
            r_max      <= w_maxNext;
            r_stat     <= w_statNext;
            r_en       <= w_enNext;
            r_cnt      <= w_cntNext;
            r_irq      <= w_irqNext;
            if (busRead) begin
                r_dataOut <= w_rdData;
            end
            r_bufWe   <= w_bufWe;
            r_bufAddr <= busAddr[BUFFER_BITS-1:0];
            r_bufData <= busDataIn;
        end
    end

    // One pixel RAM per channel: delayed write port, registered read address.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [7:0]             r_mem [2**BUFFER_BITS];
        logic [BUFFER_BITS-1:0] r_rdIx;

        always_ff @(posedge busClk) begin
            if (r_bufWe[g]) begin
                r_mem[r_bufAddr] <= r_bufData;
            end
        end

        always_ff @(posedge busClk or negedge busResetN) begin
            if (!busResetN) begin
                r_rdIx <= '0;
            end else begin
                r_rdIx <= pixelIxComb[g*BUFFER_BITS +: BUFFER_BITS];
            end
        end

        assign pixelByte[g*8 +: 8] = r_mem[r_rdIx];
        assign regMax[g*13 +: 13]  = r_max[g];
    end

    assign busDataOut   = r_dataOut;
    assign regCtrlInit  = r_init;
    assign regCtrlLimit = r_limit;
    assign regCtrlRun   = r_run;
    assign regCtrlLoop  = r_loop;
    assign regCtrl32bit = r_b32;
    assign initSlow     = r_initSlow;
    assign irq          = r_irq;

endmodule

// File: tb/tb_anton_neopixel_registers_multi.sv
// Directed self-checking bench for anton_neopixel_registers_multi (2 channels,
// 2048-byte buffers); stimulus driven on falling edges, outputs sampled there too.
module tb_anton_neopixel_registers_multi;

    localparam int CH = 2;
    localparam int BB = 11;

    logic           busClk = 1'b0;
    logic           busResetN = 1'b0;
    logic [17:0]    busAddr = '0;
    logic [7:0]     busDataIn = '0;
    logic           busWrite = 1'b0;
    logic           busRead = 1'b0;
    logic [7:0]     busDataOut;
    logic [CH*BB-1:0] pixelIxComb = '0;
    logic [CH*8-1:0]  pixelByte;
    logic [CH-1:0]  streamSyncOf = '0;
    logic [CH-1:0]  syncStart = '0;
    logic [CH-1:0]  state = '0;
    logic [CH-1:0]  initSlowDone = '0;
    logic [CH*13-1:0] regMax;
    logic [CH-1:0]  regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit, initSlow;
    logic           irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;

    anton_neopixel_registers_multi dut (
        .busClk(busClk), .busResetN(busResetN), .busAddr(busAddr), .busDataIn(busDataIn),
        .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut),
        .pixelIxComb(pixelIxComb), .pixelByte(pixelByte), .streamSyncOf(streamSyncOf),
        .syncStart(syncStart), .state(state), .initSlowDone(initSlowDone), .regMax(regMax),
        .regCtrlInit(regCtrlInit), .regCtrlLimit(regCtrlLimit), .regCtrlRun(regCtrlRun),
        .regCtrlLoop(regCtrlLoop), .regCtrl32bit(regCtrl32bit), .initSlow(initSlow), .irq(irq)
    );

    always #5 busClk = ~busClk;

    function automatic logic [17:0] regAddr(input int ch, input int off);
        return 18'h10000 | 18'(ch * 16 + off);
    endfunction

    task automatic applyWrite(input logic [17:0] a, input logic [7:0] d);
        @(negedge busClk);
        busAddr = a; busDataIn = d; busWrite = 1'b1;
        @(negedge busClk);
        busWrite = 1'b0;
    endtask

    task automatic applyRead(input logic [17:0] a, output logic [7:0] d);
        @(negedge busClk);
        busAddr = a; busRead = 1'b1;
        @(negedge busClk);
        busRead = 1'b0;
        d = busDataOut;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge busClk);
        checks++; if (regMax !== '0 || irq !== 1'b0 || busDataOut !== 8'h00 || initSlow !== '0) begin
            errors++; $display("FAIL reset_outputs: got regMax=%h irq=%b dout=%h initSlow=%b required all 0", regMax, irq, busDataOut, initSlow);
        end
        checks++; if ({regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0", {regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit});
        end
        busResetN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int o = 0; o < 8; o++) begin
                applyRead(regAddr(c, o), rd);
                checks++; if (rd !== 8'h00) begin
                    errors++; $display("FAIL reset_read ch%0d off%0d: got %h required 00", c, o, rd);
                end
            end
        end
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_shadow;
        applyWrite(regAddr(1, 0), 8'h34);
        checks++; if (regMax[25:13] !== 13'h0034) begin
            errors++; $display("FAIL shadow_maxl: got %h required 0034", regMax[25:13]);
        end
        applyWrite(regAddr(1, 1), 8'h12);
        checks++; if (regMax[25:13] !== 13'h1234 || regMax[12:0] !== 13'h0) begin
            errors++; $display("FAIL shadow_idle: got ch1=%h ch0=%h required 1234/0000", regMax[25:13], regMax[12:0]);
        end
        applyWrite(regAddr(1, 2), 8'h04);
        checks++; if (regCtrlRun !== 2'b10) begin
            errors++; $display("FAIL shadow_run: got %b required 10", regCtrlRun);
        end
        applyWrite(regAddr(1, 0), 8'h00);
        applyRead(regAddr(1, 1), rd);
        checks++; if (rd !== 8'h12) begin
            errors++; $display("FAIL shadow_maxh_read: got %h required 12", rd);
        end
        repeat (2) @(negedge busClk);
        checks++; if (regMax[25:13] !== 13'h1234) begin
            errors++; $display("FAIL shadow_hold: got %h required 1234", regMax[25:13]);
        end
        syncStart[1] = 1'b1;
        @(negedge busClk);
        syncStart[1] = 1'b0;
        checks++; if (regMax[25:13] !== 13'h1200) begin
            errors++; $display("FAIL shadow_sync: got %h required 1200", regMax[25:13]);
        end
        applyWrite(regAddr(3, 0), 8'h55);
        checks++; if (regMax[25:13] !== 13'h1200 || regMax[12:0] !== 13'h0) begin
            errors++; $display("FAIL bad_channel_write: got %h required 1200/0000", regMax);
        end
        applyWrite(regAddr(1, 2), 8'h00);
    endtask

    task automatic test_frame_count;
        applyWrite(regAddr(0, 2), 8'h08);
        applyWrite(regAddr(0, 5), 8'h01);
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL frame_irq_idle: got %b required 0", irq);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge busClk); streamSyncOf[0] = 1'b1;
        end
        @(negedge busClk); streamSyncOf[0] = 1'b0;
        applyRead(regAddr(0, 6), rd);
        checks++; if (rd !== 8'h03) begin
            errors++; $display("FAIL frame_cnt3: got %h required 03", rd);
        end
        for (int i = 0; i < 253; i++) begin
            @(negedge busClk); streamSyncOf[0] = 1'b1;
        end
        @(negedge busClk); streamSyncOf[0] = 1'b0;
        checks++; if (regCtrlRun[0] !== 1'b1 || irq !== 1'b1) begin
            errors++; $display("FAIL frame_loop: got run=%b irq=%b required 1/1", regCtrlRun[0], irq);
        end
        applyRead(regAddr(0, 6), rd);
        checks++; if (rd !== 8'h00) begin
            errors++; $display("FAIL frame_wrap: got %h required 00", rd);
        end
        applyWrite(regAddr(0, 4), 8'h01);
        @(negedge busClk);
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL frame_irq_clear: got %b required 0", irq);
        end
    endtask

    task automatic test_w1c_collision;
        @(negedge busClk); streamSyncOf[0] = 1'b1;
        @(negedge busClk); streamSyncOf[0] = 1'b0;
        busAddr = regAddr(0, 4); busDataIn = 8'h01; busWrite = 1'b1; streamSyncOf[0] = 1'b1;
        @(negedge busClk);
        busWrite = 1'b0; streamSyncOf[0] = 1'b0;
        applyRead(regAddr(0, 4), rd);
        checks++; if (rd !== 8'h01) begin
            errors++; $display("FAIL w1c_collision: got %h required 01", rd);
        end
        applyRead(regAddr(0, 6), rd);
        checks++; if (rd !== 8'h02) begin
            errors++; $display("FAIL w1c_framecnt: got %h required 02", rd);
        end
        applyWrite(regAddr(0, 4), 8'h01);
        applyRead(regAddr(0, 4), rd);
        checks++; if (rd !== 8'h00) begin
            errors++; $display("FAIL w1c_clear: got %h required 00", rd);
        end
        applyWrite(regAddr(0, 2), 8'h00);
    endtask

    task automatic test_read_write_same_cycle;
        @(negedge busClk);
        busAddr = regAddr(0, 0); busDataIn = 8'h77; busWrite = 1'b1; busRead = 1'b1;
        @(negedge busClk);
        busWrite = 1'b0; busRead = 1'b0;
        checks++; if (busDataOut !== 8'h00) begin
            errors++; $display("FAIL rw_prewrite: got %h required 00", busDataOut);
        end
        applyRead(regAddr(0, 0), rd);
        checks++; if (rd !== 8'h77 || regMax[12:0] !== 13'h0077) begin
            errors++; $display("FAIL rw_postwrite: got %h regMax=%h required 77/0077", rd, regMax[12:0]);
        end
    endtask

    task automatic test_init;
        state[1] = 1'b1;
        applyWrite(regAddr(1, 2), 8'h1F);
        @(negedge busClk);
        checks++; if ({regCtrlLimit[1], regCtrlRun[1], regCtrlLoop[1], regCtrl32bit[1]} !== 4'b0000
                      || regCtrlInit[1] !== 1'b1 || initSlow[1] !== 1'b1) begin
            errors++; $display("FAIL init_hold: got lrl3=%b init=%b initSlow=%b required 0000/1/1",
                {regCtrlLimit[1], regCtrlRun[1], regCtrlLoop[1], regCtrl32bit[1]}, regCtrlInit[1], initSlow[1]);
        end
        applyRead(regAddr(1, 3), rd);
        checks++; if (rd !== 8'h03) begin
            errors++; $display("FAIL init_status: got %h required 03", rd);
        end
        @(negedge busClk); initSlowDone[1] = 1'b1;
        @(negedge busClk); initSlowDone[1] = 1'b0;
        checks++; if (regCtrlInit[1] !== 1'b0 || initSlow[1] !== 1'b0) begin
            errors++; $display("FAIL init_done: got init=%b initSlow=%b required 0/0", regCtrlInit[1], initSlow[1]);
        end
        state[1] = 1'b0;
        applyWrite(regAddr(1, 4), 8'h01);
        applyRead(regAddr(1, 4), rd);
        checks++; if (rd !== 8'h02) begin
            errors++; $display("FAIL init_stat_w1c_other: got %h required 02", rd);
        end
        checks++; if (irq !== 1'b0) begin
            errors++; $display("FAIL init_irq_masked: got %b required 0", irq);
        end
        applyWrite(regAddr(1, 4), 8'h02);
        applyRead(regAddr(1, 4), rd);
        checks++; if (rd !== 8'h00) begin
            errors++; $display("FAIL init_stat_clear: got %h required 00", rd);
        end
    endtask

    task automatic test_buffer;
        applyWrite(18'h00005, 8'h11);
        applyWrite(18'h04005, 8'hA5);
        applyWrite(18'h04006, 8'h5A);
        applyRead(18'h04005, rd);
        checks++; if (rd !== 8'hFF) begin
            errors++; $display("FAIL buf_read: got %h required FF", rd);
        end
        applyRead(18'h08005, rd);
        checks++; if (rd !== 8'h00) begin
            errors++; $display("FAIL buf_read_badch: got %h required 00", rd);
        end
        pixelIxComb = {11'd5, 11'd5};
        @(negedge busClk);
        checks++; if (pixelByte !== 16'hA511) begin
            errors++; $display("FAIL buf_pixel: got %h required A511", pixelByte);
        end
        pixelIxComb = {11'd6, 11'd5};
        @(negedge busClk);
        checks++; if (pixelByte !== 16'h5A11) begin
            errors++; $display("FAIL buf_latency: got %h required 5A11", pixelByte);
        end
        pixelIxComb = {11'd5, 11'd5};
    endtask

    task automatic test_async_reset;
        applyWrite(regAddr(1, 2), 8'h04);
        checks++; if (regMax[25:13] !== 13'h1200 || regCtrlRun[1] !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got %h run=%b required 1200/1", regMax[25:13], regCtrlRun[1]);
        end
        applyRead(18'h04005, rd);
        @(negedge busClk);
        #2 busResetN = 1'b0;
        #1;
        checks++; if (regMax !== '0 || regCtrlRun !== '0 || busDataOut !== 8'h00 || irq !== 1'b0) begin
            errors++; $display("FAIL areset_now: got regMax=%h run=%b dout=%h irq=%b required 0", regMax, regCtrlRun, busDataOut, irq);
        end
        @(negedge busClk);
        busResetN = 1'b1;
        @(negedge busClk);
        checks++; if (pixelByte[15:8] !== 8'hA5) begin
            errors++; $display("FAIL areset_ram_kept: got %h required A5", pixelByte[15:8]);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_shadow();
        test_frame_count();
        test_w1c_collision();
        test_read_write_same_cycle();
        test_init();
        test_buffer();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
